popcount_accum_int16: RTL and testbench

Sequential stage downstream of the combinational 16-bit popcount. It accepts a stream of 16-bit words over a valid/ready handshake and computes each word's popcount. It registers that count and accumulates it over a frame delimited by `in_last`. It then presents the frame total, the word count and a saturation flag on an output valid/ready handshake. It sits between a word source (memory or bus reader) and any consumer of per-frame bit counts.

---
 rtl/popcount_pkg.sv | 32 +++
 rtl/popcount_int16.sv | 17 +
 rtl/popcount_accum_int16.sv | 110 +++++++++++
 tb/tb_popcount_accum_int16.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types, widths and the saturating adder used by the popcount accumulator.
// Any block that counts set bits per frame imports this package.
package popcount_pkg;

    localparam int POPCNT_W  = 5;
    localparam int WORD_W    = 16;
    localparam int SAT_MAX_W = 32;

    typedef enum logic {
        PC_ACCUM,
        PC_DONE
    } pc_state_t;

    // The result packs the overflow flag in the MSB above a value clamped to 2^width-1.
    // The width argument must not exceed SAT_MAX_W.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
        if (sum > max_val) begin
            sat_add = {1'b1, max_val[SAT_MAX_W-1:0]};
        end else begin
            sat_add = {1'b0, sum[SAT_MAX_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/popcount_int16.sv
// Combinational population count of one 16-bit word.
// Its output is the per-word count that feeds the pipeline register in popcount_accum_int16.
module popcount_int16
    import popcount_pkg::*;
(
    input  logic [WORD_W-1:0]   data,
    output logic [POPCNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count = count + POPCNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_accum_int16.sv
// Per-frame popcount accumulator: counts set bits and words over an in_last-delimited frame
// and holds the total on a valid/ready output until the consumer takes it.
module popcount_accum_int16
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic [CNT_WIDTH-1:0] out_words,
    output logic                 out_sat
);

    pc_state_t             state;
    pc_state_t             state_next;
    logic                  p_valid;
    logic [POPCNT_W-1:0]   p_cnt;
    logic                  p_last;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [CNT_WIDTH-1:0]  words;
    logic [CNT_WIDTH-1:0]  words_next;
    logic                  sat;
    logic                  sat_next;
    logic [POPCNT_W-1:0]   word_cnt;
    logic                  in_hs;
    logic [SAT_MAX_W:0]    acc_res;
    logic [SAT_MAX_W:0]    words_res;
    logic                  unused_res_bits;

    popcount_int16 u_popcount (
        .data  (in_data),
        .count (word_cnt)
    );

    // A pending last word blocks the next frame from entering before the result is out.
    assign in_ready  = (state == PC_ACCUM) && !(p_valid && p_last);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state == PC_DONE);
    assign out_count = acc;
    assign out_words = words;
    assign out_sat   = sat;

    assign acc_res   = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(p_cnt), ACC_WIDTH);
    assign words_res = sat_add(SAT_MAX_W'(words), SAT_MAX_W'(1), CNT_WIDTH);
    // Bits above the target widths are always zero after clamping.
    assign unused_res_bits = ^{acc_res, words_res};

    always_comb begin
        state_next = state;
        acc_next   = acc;
        words_next = words;
        sat_next   = sat;
        unique case (state)
            PC_ACCUM: begin
                if (p_valid) begin
                    acc_next   = acc_res[ACC_WIDTH-1:0];
                    words_next = words_res[CNT_WIDTH-1:0];
                    sat_next   = sat | acc_res[SAT_MAX_W] | words_res[SAT_MAX_W];
                    if (p_last) begin
                        state_next = PC_DONE;
                    end
                end
            end
            PC_DONE: begin
                if (out_ready) begin
                    acc_next   = '0;
                    words_next = '0;
                    sat_next   = 1'b0;
                    state_next = PC_ACCUM;
                end
            end
            default: begin
                state_next = PC_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PC_ACCUM;
            p_valid <= 1'b0;
            p_cnt   <= '0;
            p_last  <= 1'b0;
            acc     <= '0;
            words   <= '0;
            sat     <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            words <= words_next;
            sat   <= sat_next;
            if (state == PC_ACCUM) begin
                p_valid <= in_hs;
                p_cnt   <= word_cnt;
                p_last  <= in_last;
            end
        end
    end

endmodule

// File: tb/tb_popcount_accum_int16.sv
// Directed scoreboard bench for popcount_accum_int16: a default-width instance plus an
// ACC_WIDTH=5 instance for saturation, both checked against a bench-side reference model.
module tb_popcount_accum_int16;

    typedef struct {
        int unsigned count;
        int unsigned words;
        bit          sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_last = '0;
    logic [1:0]  out_ready = '0;
    logic [15:0] in_data [2];
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_sat;
    logic [23:0] count0;
    logic [4:0]  count1;
    logic [15:0] words0;
    logic [15:0] words1;

    int          testCount = 0;
    int          failCount = 0;
    int unsigned acc_m [2];
    int unsigned words_m [2];
    bit          sat_m [2];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];

    always #5 clk = ~clk;

    popcount_accum_int16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_last   (in_last[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_count (count0),
        .out_words (words0),
        .out_sat   (out_sat[0])
    );

    popcount_accum_int16 #(.ACC_WIDTH(5)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_last   (in_last[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_count (count1),
        .out_words (words1),
        .out_sat   (out_sat[1])
    );

    task automatic compare(input string name, input longint unsigned obs, input longint unsigned exp_v);
        testCount++;
        assert (obs === exp_v) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp_v);
        end
    endtask

    function automatic longint unsigned obsCount(input int d);
        return (d == 0) ? longint'(count0) : longint'(count1);
    endfunction

    function automatic longint unsigned obsWords(input int d);
        return (d == 0) ? longint'(words0) : longint'(words1);
    endfunction

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            acc_m[d]   = 0;
            words_m[d] = 0;
            sat_m[d]   = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic modelWord(input int d, input logic [15:0] data, input bit last);
        int unsigned acc_max;
        exp_t        e;
        acc_max = (d == 0) ? 32'h00FF_FFFF : 32'd31;
        acc_m[d] = acc_m[d] + $countones(data);
        if (acc_m[d] > acc_max) begin
            acc_m[d] = acc_max;
            sat_m[d] = 1'b1;
        end
        words_m[d] = words_m[d] + 1;
        if (words_m[d] > 65535) begin
            words_m[d] = 65535;
            sat_m[d]   = 1'b1;
        end
        if (last) begin
            e.count = acc_m[d];
            e.words = words_m[d];
            e.sat   = sat_m[d];
            if (d == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
            acc_m[d]   = 0;
            words_m[d] = 0;
            sat_m[d]   = 1'b0;
        end
    endtask

    // Hold one word on the input until it is accepted, then record it in the model.
    task automatic applyStimulus(input int d, input logic [15:0] data, input bit last);
        bit accepted;
        accepted    = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        in_data[d]  = 16'($urandom);
        compare("word_accepted", accepted, 1);
        if (accepted) modelWord(d, data, last);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_data[0] = 16'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for a result, compare it with the scoreboard, optionally stall, then retire it.
    task automatic checkOutput(input int d, input int hold, input bit pulse);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid[d]) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        compare("out_valid_seen", seen, 1);
        if (seen) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                compare("scoreboard_nonempty", 0, 1);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                compare("out_count", obsCount(d), e.count);
                compare("out_words", obsWords(d), e.words);
                compare("out_sat", out_sat[d], e.sat);
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    #1;
                    compare("stall_out_valid", out_valid[d], 1);
                    compare("stall_in_ready", in_ready[d], 0);
                    compare("stall_out_count", obsCount(d), e.count);
                    compare("stall_out_words", obsWords(d), e.words);
                end
            end
            if (pulse) begin
                out_ready[d] = 1'b1;
                @(posedge clk);
                #1;
                out_ready[d] = 1'b0;
                compare("post_hs_out_valid", out_valid[d], 0);
                compare("post_hs_in_ready", in_ready[d], 1);
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_data[0] = '0;
        in_data[1] = '0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        compare("reset_out_valid", out_valid[0], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare("reset_in_ready", in_ready[0], 1);
        compare("reset_out_valid_after", out_valid[0], 0);
        compare("reset_out_count", count0, 0);
        compare("reset_out_words", words0, 0);
        compare("reset_out_sat", out_sat[0], 0);

        // Single full word: result becomes visible one cycle after the last-word edge.
        applyStimulus(0, 16'hFFFF, 1'b1);
        compare("latency_out_valid_early", out_valid[0], 0);
        compare("latency_in_ready_low", in_ready[0], 0);
        @(posedge clk);
        #1;
        compare("latency_out_valid", out_valid[0], 1);
        checkOutput(0, 0, 1'b1);

        // Bubbled frame, then a 5-cycle stall on its result.
        applyStimulus(0, 16'h0001, 1'b0);
        idleCycles(2);
        applyStimulus(0, 16'h8000, 1'b0);
        idleCycles(1);
        applyStimulus(0, 16'hAAAA, 1'b1);
        checkOutput(0, 5, 1'b1);

        applyStimulus(0, 16'h00FF, 1'b1);
        checkOutput(0, 0, 1'b1);

        // Saturating instance: 48 set bits clamp to 31, next frame starts clean.
        applyStimulus(1, 16'hFFFF, 1'b0);
        applyStimulus(1, 16'hFFFF, 1'b0);
        applyStimulus(1, 16'hFFFF, 1'b1);
        checkOutput(1, 0, 1'b1);
        applyStimulus(1, 16'h0003, 1'b1);
        checkOutput(1, 0, 1'b1);

        // Mid-frame reset discards the partial frame.
        applyStimulus(0, 16'hFFFF, 1'b0);
        applyStimulus(0, 16'hFFFF, 1'b0);
        rst_n = 1'b0;
        #2;
        compare("midreset_out_count", count0, 0);
        resetModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare("midreset_in_ready", in_ready[0], 1);
        applyStimulus(0, 16'h0007, 1'b1);
        checkOutput(0, 0, 1'b1);

        // Back-to-back frames with the consumer always ready.
        out_ready[0] = 1'b1;
        fork
            begin
                applyStimulus(0, 16'h0F0F, 1'b1);
                applyStimulus(0, 16'h1111, 1'b0);
                applyStimulus(0, 16'h2222, 1'b1);
            end
            begin
                checkOutput(0, 0, 1'b0);
                checkOutput(0, 0, 1'b0);
            end
        join
        out_ready[0] = 1'b0;

        compare("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
